// File: rtl/can_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : can_tx_scheduler
// Description : Picks the pending TX mailbox with the lowest CAN ID, launches it
//               on the frame engine, retries lost arbitration and reports
//               done/err per mailbox. Optional mailbox abort: CAN_TXS_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module can_tx_scheduler #(
   parameter int NUM_MB    = 4,
   parameter int ID_W      = 11,
   parameter int DATA_W    = 32,
   parameter int RETRY_MAX = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_MB-1:0]        mb_valid,
   input  logic [NUM_MB*ID_W-1:0]   mb_id,
   input  logic [NUM_MB*DATA_W-1:0] mb_data,
`ifdef CAN_TXS_ABORT_EN
   input  logic [NUM_MB-1:0]        mb_abort,
`endif
   output logic [NUM_MB-1:0]        mb_done,
   output logic [NUM_MB-1:0]        mb_err,
   input  logic                     bus_idle,
   output logic                     tx_start,
   output logic [ID_W-1:0]          tx_id,
   output logic [DATA_W-1:0]        tx_data,
   input  logic                     tx_complete,
   input  logic                     tx_lost_arb,
   output logic                     busy
);

   localparam int         SEL_W        = $clog2(NUM_MB);
   localparam logic [7:0] c_RETRY_LAST = 8'(RETRY_MAX - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SELECT = 2'd1,
      S_LAUNCH = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   state_t            r_state;
   logic [SEL_W-1:0]  r_sel;
   logic [7:0]        r_retry;

   logic [NUM_MB-1:0] w_cand;
   logic [NUM_MB-1:0] w_abort_err;
   logic              w_launch_abort;
   logic              w_any;
   logic [SEL_W-1:0]  w_best_sel;
   logic [ID_W-1:0]   w_best_id;
   logic [DATA_W-1:0] w_best_data;

`ifdef CAN_TXS_ABORT_EN
   logic [NUM_MB-1:0] r_aborted;
   logic [NUM_MB-1:0] w_sel_oh;
   logic [NUM_MB-1:0] w_abort_ok;

   assign w_sel_oh = NUM_MB'(1) << r_sel;
   // The frame already handed to the engine cannot be aborted; it must finish.
   assign w_abort_ok     = mb_abort & mb_valid & ~r_aborted &
                           ((r_state == S_WAIT) ? ~w_sel_oh : {NUM_MB{1'b1}});
   assign w_abort_err    = w_abort_ok;
   assign w_launch_abort = (r_state == S_LAUNCH) && (|(w_abort_ok & w_sel_oh));
   assign w_cand         = mb_valid & ~r_aborted & ~mb_abort;

   // Aborted mailboxes stay out of arbitration until their owner drops valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_aborted <= '0;
      else     r_aborted <= (r_aborted | w_abort_ok) & mb_valid;
   end
`else
   assign w_abort_err    = '0;
   assign w_launch_abort = 1'b0;
   assign w_cand         = mb_valid;
`endif

   // Strict less-than while scanning upward gives ties to the lower index.
   always_comb begin
      w_any       = 1'b0;
      w_best_sel  = '0;
      w_best_id   = '1;
      w_best_data = '0;
      for (int i = 0; i < NUM_MB; i++) begin
         if (w_cand[i] && (!w_any || (mb_id[i*ID_W +: ID_W] < w_best_id))) begin
            w_any       = 1'b1;
            w_best_sel  = SEL_W'(i);
            w_best_id   = mb_id[i*ID_W +: ID_W];
            w_best_data = mb_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_sel    <= '0;
         r_retry  <= '0;
         tx_start <= 1'b0;
         tx_id    <= '0;
         tx_data  <= '0;
         mb_done  <= '0;
         mb_err   <= '0;
      end else begin
         tx_start <= 1'b0;
         mb_done  <= '0;
         mb_err   <= w_abort_err;
         case (r_state)
            S_IDLE: begin
               if (|w_cand) r_state <= S_SELECT;
            end
            S_SELECT: begin
               if (w_any) begin
                  r_sel   <= w_best_sel;
                  tx_id   <= w_best_id;
                  tx_data <= w_best_data;
                  if (w_best_sel != r_sel) r_retry <= '0;
                  r_state <= S_LAUNCH;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_LAUNCH: begin
               if (w_launch_abort) begin
                  r_state <= S_IDLE;
               end else if (bus_idle) begin
                  tx_start <= 1'b1;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (tx_complete) begin
                  mb_done[r_sel] <= 1'b1;
                  r_retry        <= '0;
                  r_state        <= S_IDLE;
               end else if (tx_lost_arb) begin
                  if (r_retry >= c_RETRY_LAST) begin
                     mb_err[r_sel] <= 1'b1;
                     r_retry       <= '0;
                  end else begin
                     r_retry <= r_retry + 8'd1;
                  end
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire
